// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_unit
//  Description : Iterative signed multiply (radix-2 Booth) / divide (restoring)
//                unit with a one-cycle writeback strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_reg,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_reg,
  output logic             exception
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [4:0]         rd_q, rd_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic [4:0]         rreg_q, rreg_d;

  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic               mul_fits;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic               div_ovf;

  // Booth step: the sum is one bit wider than the high half so that
  // subtracting the most negative multiplicand stays exact before the shift.
  always_comb begin
    booth_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_sum + {opa_q[WIDTH-1], opa_q};
      2'b10:   booth_sum = booth_sum - {opa_q[WIDTH-1], opa_q};
      default: booth_sum = booth_sum;
    endcase
    booth_next = {booth_sum, acc_q[WIDTH:1]};
    mul_fits   = (&booth_next[2*WIDTH:WIDTH]) | ~(|booth_next[2*WIDTH:WIDTH]);
  end

  always_comb begin
    div_sh   = {rem_q, quo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, dvs_q});
    div_diff = div_sh[WIDTH-1:0] - dvs_q;
    rem_next = div_ge ? div_diff : div_sh[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], div_ge};
    div_ovf  = (opa_q == C_MIN) && (&opb_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rreg_d  = rreg_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_mul || start_div) begin
          opa_d   = operand_a;
          opb_d   = operand_b;
          rd_d    = dest_reg;
          state_d = start_mul ? S_MUL : S_DIV;
        end
      end

      S_MUL: begin
        if (cnt_q == '0) begin
          acc_d = {{WIDTH{1'b0}}, opb_q, 1'b0};
          cnt_d = cnt_q + 1'b1;
        end else begin
          acc_d = booth_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            rreg_d  = rd_q;
            exc_d   = ~mul_fits;
            res_d   = mul_fits ? booth_next[WIDTH:1] : '0;
          end
        end
      end

      S_DIV: begin
        if (cnt_q == '0) begin
          dvs_d = opb_q[WIDTH-1] ? -opb_q : opb_q;
          quo_d = opa_q[WIDTH-1] ? -opa_q : opa_q;
          rem_d = '0;
          neg_d = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
          cnt_d = cnt_q + 1'b1;
        end else if (opb_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
          rreg_d  = rd_q;
          exc_d   = 1'b1;
          res_d   = '0;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            rreg_d  = rd_q;
            exc_d   = div_ovf;
            res_d   = div_ovf ? '0 : (neg_q ? -quo_next : quo_next);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rreg_q  <= rreg_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = res_q;
  assign result_reg   = rreg_q;
  assign exception    = exc_q;

endmodule
`default_nettype wire
